branch_hazard_controller: RTL and testbench

BRANCH_HAZARD_CONTROLLER -- requirements
Module: branch_hazard_controller

---
 rtl/branch_hazard_controller.sv | 154 +++++++++++++++
 tb/tb_branch_hazard_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_controller.sv
// Branch hazard controller: stalls conditional branches until in-flight flag writers
// have committed, redirects the PC on taken branches and keeps branch statistics.
module branch_hazard_controller #(
    parameter int CNT_WIDTH  = 16,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [7:0]            id_operation,
    input  logic                  id_writes_flags,
    input  logic                  flag_update,
    input  logic                  take_branch_target,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  pc_load,
    output logic                  flush_fetch,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  pend_overflow,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t state;
    state_t state_next;
    logic   is_branch;
    logic   is_cond;
    logic   pend_zero;
    logic   resolvable;
    logic   stall;
    logic   resolve;
    logic   pend_inc;
    logic   pend_dec;
    logic   op_unused;

    assign is_branch  = id_valid && (id_operation[7:3] == 5'b00111);
    assign is_cond    = is_branch && (id_operation[1:0] != 2'b00);
    assign pend_zero  = (pending == '0);
    assign resolvable = !is_cond || pend_zero;
    assign op_unused  = id_operation[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_branch) begin
                    if (!resolvable) begin
                        state_next = WAIT_FLAGS;
                    end else if (take_branch_target) begin
                        state_next = FLUSH;
                    end
                end
            end
            WAIT_FLAGS: begin
                if (pend_zero) begin
                    state_next = take_branch_target ? FLUSH : IDLE;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs are forced low while reset is held so no redirect escapes a reset cycle.
    always_comb begin
        stall       = 1'b0;
        pc_load     = 1'b0;
        flush_fetch = 1'b0;
        resolve     = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (is_branch) begin
                        if (!resolvable) begin
                            stall = 1'b1;
                        end else begin
                            resolve     = 1'b1;
                            pc_load     = take_branch_target;
                            flush_fetch = take_branch_target;
                        end
                    end
                end
                WAIT_FLAGS: begin
                    if (!pend_zero) begin
                        stall = 1'b1;
                    end else begin
                        resolve     = 1'b1;
                        pc_load     = take_branch_target;
                        flush_fetch = take_branch_target;
                    end
                end
                FLUSH:   flush_fetch = 1'b1;
                default: ;
            endcase
        end
    end

    assign stall_fetch  = stall;
    assign stall_decode = stall;
    assign fsm_state    = state;

    assign pend_inc = id_valid && id_writes_flags && !stall && (state != FLUSH);
    assign pend_dec = flag_update;

    // A simultaneous issue and commit cancel out, so neither limit check applies.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending       <= '0;
            pend_overflow <= 1'b0;
        end else if (pend_inc && !pend_dec) begin
            if (pending == PEND_MAX) begin
                pend_overflow <= 1'b1;
            end else begin
                pending <= pending + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            if (pend_zero) begin
                pend_overflow <= 1'b1;
            end else begin
                pending <= pending - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (resolve) begin
            branch_count <= branch_count + 1'b1;
            if (take_branch_target) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Bench for branch_hazard_controller: directed vector table, counter wrap sequence and
// randomized traffic checked against a rule-level reference model every cycle.
module tb_branch_hazard_controller;

    localparam int CW       = 8;
    localparam int PW       = 2;
    localparam int PEND_MAX = (1 << PW) - 1;
    localparam int CNT_MASK = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          id_valid;
    logic [7:0]    id_operation;
    logic          id_writes_flags;
    logic          flag_update;
    logic          take_branch_target;
    logic          stall_fetch;
    logic          stall_decode;
    logic          pc_load;
    logic          flush_fetch;
    logic [PW-1:0] pending;
    logic          pend_overflow;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] taken_count;
    logic [1:0]    fsm_state;

    branch_hazard_controller #(.CNT_WIDTH(CW), .PEND_WIDTH(PW)) dut (
        .clock              (clock),
        .reset              (reset),
        .id_valid           (id_valid),
        .id_operation       (id_operation),
        .id_writes_flags    (id_writes_flags),
        .flag_update        (flag_update),
        .take_branch_target (take_branch_target),
        .stall_fetch        (stall_fetch),
        .stall_decode       (stall_decode),
        .pc_load            (pc_load),
        .flush_fetch        (flush_fetch),
        .pending            (pending),
        .pend_overflow      (pend_overflow),
        .branch_count       (branch_count),
        .taken_count        (taken_count),
        .fsm_state          (fsm_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model: the spec's rules in terms of counts and flags
    int m_pend, m_br, m_tk;
    bit m_ovf, m_wait, m_flush;

    // DUT outputs sampled at the falling edge of the last cycle
    int s_stall, s_pc, s_fl, s_pend, s_ovf, s_br, s_tk;

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] op;
        bit         wf;
        bit         fu;
        bit         tk;
        bit         e_stall;
        bit         e_pc;
        bit         e_fl;
        int         e_pend;
        bit         e_ovf;
        int         e_br;
        int         e_tk;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_br = 0; m_tk = 0;
        m_ovf = 0; m_wait = 0; m_flush = 0;
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [7:0] op,
                         input bit wf, input bit fu, input bit tk);
        bit is_br, is_c, blocked, e_stall, e_pc, e_fl, res, inc;
        int e_state;
        reset = rst; id_valid = v; id_operation = op;
        id_writes_flags = wf; flag_update = fu; take_branch_target = tk;
        is_br = v && (op[7:3] == 5'b00111);
        is_c  = is_br && (op[1:0] != 2'b00);
        e_stall = 0; e_pc = 0; e_fl = 0; res = 0;
        if (!rst) begin
            if (m_flush) begin
                e_fl = 1;
            end else if (m_wait || is_br) begin
                blocked = (m_pend != 0) && (m_wait || is_c);
                if (blocked) e_stall = 1;
                else begin
                    res = 1; e_pc = tk; e_fl = tk;
                end
            end
        end
        e_state = m_flush ? 2 : (m_wait ? 1 : 0);
        @(negedge clock);
        s_stall = int'(stall_fetch); s_pc = int'(pc_load); s_fl = int'(flush_fetch);
        s_pend = int'(pending); s_ovf = int'(pend_overflow);
        s_br = int'(branch_count); s_tk = int'(taken_count);
        check("stall_fetch", 32'(stall_fetch), 32'(e_stall));
        check("stall_decode", 32'(stall_decode), 32'(e_stall));
        check("pc_load", 32'(pc_load), 32'(e_pc));
        check("flush_fetch", 32'(flush_fetch), 32'(e_fl));
        check("pending", 32'(pending), 32'(m_pend));
        check("pend_overflow", 32'(pend_overflow), 32'(m_ovf));
        check("branch_count", 32'(branch_count), 32'(m_br));
        check("taken_count", 32'(taken_count), 32'(m_tk));
        check("fsm_state", 32'(fsm_state), 32'(e_state));
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            inc = v && wf && !e_stall && !m_flush;
            if (inc && !fu) begin
                if (m_pend == PEND_MAX) m_ovf = 1;
                else m_pend++;
            end else if (fu && !inc) begin
                if (m_pend == 0) m_ovf = 1;
                else m_pend--;
            end
            if (res) begin
                m_br = (m_br + 1) & CNT_MASK;
                if (tk) m_tk = (m_tk + 1) & CNT_MASK;
            end
            m_flush = res && tk;
            m_wait  = e_stall;
        end
        cyc++;
        #1;
    endtask

    task automatic add(input bit rst, input bit v, input logic [7:0] op, input bit wf,
                       input bit fu, input bit tk, input bit st, input bit pc, input bit fl,
                       input int pend, input bit ovf, input int br, input int tkc);
        vec_t r;
        r.rst = rst; r.v = v; r.op = op; r.wf = wf; r.fu = fu; r.tk = tk;
        r.e_stall = st; r.e_pc = pc; r.e_fl = fl; r.e_pend = pend; r.e_ovf = ovf;
        r.e_br = br; r.e_tk = tkc;
        vq.push_back(r);
    endtask

    initial begin
        bit          r_rst, r_v, r_wf, r_fu, r_tk;
        logic [7:0]  r_op;

        reset = 1'b1; id_valid = 0; id_operation = 8'h00;
        id_writes_flags = 0; flag_update = 0; take_branch_target = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        //  rst v  op    wf fu tk | st pc fl pend ovf br tk
        add(0, 1, 8'h38, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0);  // unconditional taken
        add(0, 1, 8'h38, 0, 0, 1,   0, 0, 1, 0, 0, 1, 1);  // FLUSH ignores decode
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 1, 1);  // two flag writers
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 1, 0, 1, 1);
        add(0, 1, 8'h3E, 0, 1, 0,   1, 0, 0, 2, 0, 1, 1);  // conditional waits
        add(0, 1, 8'h3E, 0, 1, 0,   1, 0, 0, 1, 0, 1, 1);
        add(0, 1, 8'h3E, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);  // resolves not taken
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1);
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 2, 1);
        add(0, 1, 8'h00, 1, 1, 0,   0, 0, 0, 1, 0, 2, 1);  // inc + dec at 1
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1);
        add(0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 1, 0, 2, 1);
        add(0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 0, 0, 2, 1);  // underflow
        add(1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 2, 1);  // sticky until reset
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // four increments
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 2, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 3, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0);
        add(0, 1, 8'h3F, 0, 0, 1,   1, 0, 0, 3, 1, 0, 0);  // into WAIT_FLAGS
        add(0, 1, 8'h3F, 0, 1, 1,   1, 0, 0, 3, 1, 0, 0);
        add(1, 1, 8'h3F, 0, 1, 1,   0, 0, 0, 2, 1, 0, 0);  // reset in WAIT_FLAGS
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h38, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);  // reset in FLUSH
        add(0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h3C, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);  // uncond ignores pending
        add(0, 1, 8'h3A, 1, 1, 1,   1, 0, 0, 1, 0, 1, 0);  // stalled writer not counted
        add(0, 1, 8'h3A, 0, 0, 1,   0, 1, 1, 0, 0, 1, 0);  // resolves taken from WAIT
        add(0, 1, 8'h00, 1, 0, 0,   0, 0, 1, 0, 0, 2, 1);  // writer during FLUSH
        add(0, 0, 8'h38, 0, 0, 1,   0, 0, 0, 0, 0, 2, 1);
        add(0, 1, 8'h30, 0, 0, 1,   0, 0, 0, 0, 0, 2, 1);  // non-branch opcode

        foreach (vq[i]) begin
            cycle(vq[i].rst, vq[i].v, vq[i].op, vq[i].wf, vq[i].fu, vq[i].tk);
            check($sformatf("vec%0d.stall", i), 32'(s_stall), 32'(vq[i].e_stall));
            check($sformatf("vec%0d.pc_load", i), 32'(s_pc), 32'(vq[i].e_pc));
            check($sformatf("vec%0d.flush", i), 32'(s_fl), 32'(vq[i].e_fl));
            check($sformatf("vec%0d.pending", i), 32'(s_pend), 32'(vq[i].e_pend));
            check($sformatf("vec%0d.overflow", i), 32'(s_ovf), 32'(vq[i].e_ovf));
            check($sformatf("vec%0d.branch_count", i), 32'(s_br), 32'(vq[i].e_br));
            check($sformatf("vec%0d.taken_count", i), 32'(s_tk), 32'(vq[i].e_tk));
        end

        // counter wrap: drive both counters to all-ones, then one more taken branch
        cycle(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < CNT_MASK; i++) begin
            cycle(0, 1, 8'h38, 0, 0, 1);
            cycle(0, 0, 8'h00, 0, 0, 0);
        end
        cycle(0, 0, 8'h00, 0, 0, 0);
        check("wrap.branch_all_ones", 32'(s_br), 32'(CNT_MASK));
        check("wrap.taken_all_ones", 32'(s_tk), 32'(CNT_MASK));
        cycle(0, 1, 8'h38, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        check("wrap.branch_zero", 32'(s_br), 32'd0);
        check("wrap.taken_zero", 32'(s_tk), 32'd0);

        // randomized traffic; the decode instruction is held while the model is waiting
        cycle(1, 0, 8'h00, 0, 0, 0);
        r_v = 0; r_op = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            if (!m_wait) begin
                r_v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) r_op = 8'h38 + 8'($urandom_range(0, 7));
                else r_op = 8'($urandom);
            end
            r_wf = ($urandom_range(0, 2) == 0);
            r_fu = ($urandom_range(0, 3) == 0);
            r_tk = ($urandom_range(0, 1) == 1);
            cycle(r_rst, r_v, r_op, r_wf, r_fu, r_tk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
